// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state enum plus byte-packing and address helpers.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } load_state_e;

   localparam int unsigned BYTES_PER_WORD   = 4;
   localparam int unsigned WORD_BYTES_SHIFT = 2;
   localparam int unsigned BYTE_CNT_W       = 2;

   // Big-endian packing: earlier bytes end up in the more significant lanes.
   function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] data);
      return {word[23:0], data};
   endfunction

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] index);
      return base + ({16'd0, index} << WORD_BYTES_SHIFT);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects accepted image bytes into a 32-bit big-endian word and flags
// the handshake that completes a word.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word_next,
   output logic        word_ready
);

   logic [31:0]           word_r;
   logic [BYTE_CNT_W-1:0] byte_cnt_r;

   // Shift register and byte counter; the counter wraps to zero after the fourth byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r     <= 32'd0;
         byte_cnt_r <= {BYTE_CNT_W{1'b0}};
      end else if (clr) begin
         word_r     <= 32'd0;
         byte_cnt_r <= {BYTE_CNT_W{1'b0}};
      end else if (shift_en) begin
         word_r     <= shift_in_byte(word_r, byte_data);
         byte_cnt_r <= byte_cnt_r + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         word_r     <= word_r;
         byte_cnt_r <= byte_cnt_r;
      end
   end

   // Word including the byte being accepted now, so the writer can register it directly.
   always_comb begin
      word_next = shift_in_byte(word_r, byte_data);
      if (shift_en && (byte_cnt_r == BYTE_CNT_W'(BYTES_PER_WORD - 1))) begin
         word_ready = 1'b1;
      end else begin
         word_ready = 1'b0;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory writer: packs a byte stream into words, writes them at
// consecutive word addresses and holds the CPU in reset until the image is in.
module instr_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] word_count_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cpu_rst_o
);

   load_state_e state_r;
   logic [15:0] count_r;
   logic [15:0] index_r;
   logic [15:0] index_next_s;
   logic        accept_s;
   logic        clr_s;
   logic        count_over_s;
   logic        count_zero_s;
   logic        word_ready_s;
   logic [31:0] word_next_s;

   // Start classification and handshake decode; byte_ready_o is registered so no input reaches an output.
   always_comb begin
      count_over_s = ({16'd0, word_count_i} > DEPTH);
      count_zero_s = (word_count_i == 16'd0);
      accept_s     = byte_valid_i && byte_ready_o;
      index_next_s = index_r + 16'd1;
      if (start_i && (state_r == IDLE || state_r == DONE) && !count_over_s && !count_zero_s) begin
         clr_s = 1'b1;
      end else begin
         clr_s = 1'b0;
      end
   end

   byte_packer u_packer (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .clr        (clr_s),
      .shift_en   (accept_s),
      .byte_data  (byte_data_i),
      .word_next  (word_next_s),
      .word_ready (word_ready_s)
   );

   // Load sequencer with all interface outputs registered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r      <= IDLE;
         count_r      <= 16'd0;
         index_r      <= 16'd0;
         byte_ready_o <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= 32'd0;
         mem_data_o   <= 32'd0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         cpu_rst_o    <= 1'b0;
      end else begin
         mem_we_o <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start_i) begin
                  if (count_over_s) begin
                     err_o     <= 1'b1;
                     done_o    <= 1'b0;
                     cpu_rst_o <= 1'b0;
                     state_r   <= IDLE;
                  end else if (count_zero_s) begin
                     err_o     <= 1'b0;
                     done_o    <= 1'b1;
                     cpu_rst_o <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     count_r      <= word_count_i;
                     index_r      <= 16'd0;
                     err_o        <= 1'b0;
                     done_o       <= 1'b0;
                     cpu_rst_o    <= 1'b0;
                     busy_o       <= 1'b1;
                     byte_ready_o <= 1'b1;
                     state_r      <= RECV;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            RECV: begin
               if (word_ready_s) begin
                  mem_we_o     <= 1'b1;
                  mem_addr_o   <= word_addr(BASE_ADDR, index_r);
                  mem_data_o   <= word_next_s;
                  byte_ready_o <= 1'b0;
                  state_r      <= WRITE;
               end else begin
                  state_r <= RECV;
               end
            end
            WRITE: begin
               index_r <= index_next_s;
               if (index_next_s == count_r) begin
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  cpu_rst_o <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  byte_ready_o <= 1'b1;
                  state_r      <= RECV;
               end
            end
            default: begin
               byte_ready_o <= 1'b0;
               busy_o       <= 1'b0;
               cpu_rst_o    <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: start-control vector table plus
// randomized image loads against a queue-based expected-write model.
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] wcnt = 16'd0;
   logic        bval = 1'b0;
   logic [7:0]  bdata = 8'd0;

   logic        ready0, we0, busy0, done0, err0, cpu0;
   logic [31:0] addr0, data0;
   logic        ready1, we1, busy1, done1, err1, cpu1;
   logic [31:0] addr1, data1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] cnt;
      logic        err;
      logic        done;
      logic        cpu;
      logic        busy;
   } vec_t;

   wr_t        exp0[$];
   wr_t        exp1[$];
   logic [7:0] bq[$];
   logic [7:0] fixed_bytes[4];
   vec_t       tbl[7];

   always #5 clk = ~clk;

   instr_loader #(.DEPTH(32), .BASE_ADDR(32'h0000_0000)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .word_count_i(wcnt),
      .byte_valid_i(bval), .byte_data_i(bdata), .byte_ready_o(ready0),
      .mem_we_o(we0), .mem_addr_o(addr0), .mem_data_o(data0),
      .busy_o(busy0), .done_o(done0), .err_o(err0), .cpu_rst_o(cpu0)
   );

   instr_loader #(.DEPTH(32), .BASE_ADDR(32'h0000_0100)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .word_count_i(wcnt),
      .byte_valid_i(bval), .byte_data_i(bdata), .byte_ready_o(ready1),
      .mem_we_o(we1), .mem_addr_o(addr1), .mem_data_o(data1),
      .busy_o(busy1), .done_o(done1), .err_o(err1), .cpu_rst_o(cpu1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      wr_t w;
      if (we0) begin
         chk("ready_low_in_write0", 32'(ready0), 32'd0);
         chk("pending_write0", 32'(exp0.size() > 0), 32'd1);
         if (exp0.size() > 0) begin
            w = exp0.pop_front();
            chk("addr0", addr0, w.addr);
            chk("data0", data0, w.data);
         end
      end
      if (we1) begin
         chk("pending_write1", 32'(exp1.size() > 0), 32'd1);
         if (exp1.size() > 0) begin
            w = exp1.pop_front();
            chk("addr1", addr1, w.addr);
            chk("data1", data1, w.data);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
   endtask

   task automatic do_reset();
      tick();
      #2 rst_n = 1'b0;
      exp0.delete();
      exp1.delete();
      bq.delete();
      #1;
      chk("rst_we", 32'(we0), 32'd0);
      chk("rst_addr", addr0, 32'd0);
      chk("rst_data", data0, 32'd0);
      chk("rst_ready", 32'(ready0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_cpu", 32'(cpu0), 32'd0);
      chk("rst_cpu1", 32'(cpu1), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      bval  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bdata = 8'($urandom_range(255));
         tick();
         chk("post_rst_we", 32'(we0), 32'd0);
         chk("post_rst_ready", 32'(ready0), 32'd0);
         chk("post_rst_busy", 32'(busy0), 32'd0);
         chk("post_rst_cpu", 32'(cpu0), 32'd0);
      end
      bval = 1'b0;
   endtask

   task automatic do_load(input int n, input int stall_pct, input bit fixed_img,
                          input bit poke_start, input int abort_at);
      logic [7:0]  img[$];
      logic [31:0] w;
      int          t;
      bit          seen;
      bit          prev_we;
      for (int i = 0; i < 4 * n; i++) begin
         if (fixed_img) img.push_back(fixed_bytes[i % 4]);
         else           img.push_back(8'($urandom_range(255)));
      end
      for (int i = 0; i < n; i++) begin
         w = (32'(img[4*i]) << 24) | (32'(img[4*i+1]) << 16) | (32'(img[4*i+2]) << 8) | 32'(img[4*i+3]);
         exp0.push_back('{32'(4 * i), w});
         exp1.push_back('{32'h100 + 32'(4 * i), w});
      end
      bq = img;
      tick();
      start = 1'b1;
      wcnt  = 16'(n);
      tick();
      start = 1'b0;
      wcnt  = 16'($urandom);
      chk("start_busy", 32'(busy0), 32'd1);
      chk("start_ready", 32'(ready0), 32'd1);
      chk("start_cpu_drop", 32'(cpu0), 32'd0);
      chk("start_done_clear", 32'(done0), 32'd0);
      chk("start_err_clear", 32'(err0), 32'd0);
      t = 1;
      seen = 1'b0;
      prev_we = 1'b0;
      while (t < 40 * n + 50) begin
         if (done0) begin
            seen = 1'b1;
            break;
         end
         chk("cpu_held", 32'(cpu0), 32'd0);
         if (abort_at > 0 && t == abort_at) break;
         if (bq.size() > 0 && $urandom_range(99) >= stall_pct) begin
            bval  = 1'b1;
            bdata = bq[0];
            if (ready0) void'(bq.pop_front());
         end else begin
            bval  = 1'b0;
            bdata = 8'($urandom_range(255));
         end
         start = (poke_start && t == 2);
         prev_we = we0;
         tick();
         t++;
      end
      start = 1'b0;
      bval  = 1'b0;
      if (abort_at > 0) begin
         do_reset();
         return;
      end
      chk("load_done", 32'(seen), 32'd1);
      chk("done_after_write", 32'(prev_we), 32'd1);
      if (stall_pct == 0) chk("load_cycles", 32'(t), 32'(5 * n + 1));
      chk("end_cpu", 32'(cpu0), 32'd1);
      chk("end_busy", 32'(busy0), 32'd0);
      chk("end_err", 32'(err0), 32'd0);
      chk("end_ready", 32'(ready0), 32'd0);
      chk("end_done1", 32'(done1), 32'd1);
      chk("end_cpu1", 32'(cpu1), 32'd1);
      chk("writes_left0", 32'(exp0.size()), 32'd0);
      chk("writes_left1", 32'(exp1.size()), 32'd0);
      chk("bytes_left", 32'(bq.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fixed_bytes = '{8'h20, 8'h08, 8'h00, 8'h05};
      tbl[0] = '{16'd0,     1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{16'd33,    1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{16'hFFFF,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'd32,    1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{16'd0,     1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{16'd1,     1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{16'd33,    1'b1, 1'b0, 1'b0, 1'b0};

      do_reset();

      for (int i = 0; i < 7; i++) begin
         tick();
         start = 1'b1;
         wcnt  = tbl[i].cnt;
         tick();
         start = 1'b0;
         chk("tbl_err", 32'(err0), 32'(tbl[i].err));
         chk("tbl_done", 32'(done0), 32'(tbl[i].done));
         chk("tbl_cpu", 32'(cpu0), 32'(tbl[i].cpu));
         chk("tbl_busy", 32'(busy0), 32'(tbl[i].busy));
         chk("tbl_ready", 32'(ready0), 32'(tbl[i].busy));
         tick();
         chk("tbl_err_hold", 32'(err0), 32'(tbl[i].err));
         chk("tbl_cpu_hold", 32'(cpu0), 32'(tbl[i].cpu));
         if (tbl[i].busy) do_reset();
      end

      do_load(1, 0, 1'b1, 1'b0, 0);
      do_load(3, 0, 1'b0, 1'b0, 8);
      do_load(3, 50, 1'b0, 1'b0, 0);
      do_load(2, 0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 6; k++) begin
         do_load(int'($urandom_range(1, 6)), int'($urandom_range(0, 70)), 1'b0, 1'b0, 0);
      end
      do_load(32, 20, 1'b0, 1'b0, 0);
      do_load(2, 0, 1'b0, 1'b0, 0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction-memory interface that the single-cycle CPU reads through its program counter.
- Accepts a byte stream from a host or boot channel with a valid/ready handshake.
- Packs each four bytes into one big-endian 32-bit MIPS word and writes the words into instruction memory at consecutive word-aligned addresses.
- Holds the CPU in reset until the image is fully loaded, then releases it.

Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory; legal word indices are 0..DEPTH-1.
- BASE_ADDR, 32'd0, byte address of the first word written.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle load request; sampled only in IDLE and DONE.
- word_count_i  input  16  number of words to load; sampled on the accepted start_i.
- byte_valid_i  input  1  byte_data_i carries a valid byte.
- byte_data_i  input  8  next image byte, most significant byte of each word first.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- mem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write; always a multiple of 4.
- mem_data_o  output  32  word to write.
- busy_o  output  1  load in progress.
- done_o  output  1  last load completed successfully.
- err_o  output  1  last start_i was rejected because word_count_i > DEPTH.
- cpu_rst_o  output  1  active-low reset to the CPU; low holds the CPU in reset.

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM goes to IDLE; byte counter, word index and packing register clear.
  - mem_we_o=0, mem_addr_o=0, mem_data_o=0, byte_ready_o=0, busy_o=0, done_o=0, err_o=0, cpu_rst_o=0.
  - A reset mid-load abandons the load. Words already written stay in memory. The CPU remains held in reset.
- States: IDLE, RECV, WRITE, DONE. State encoding is a 2-bit enum.
- IDLE and DONE, on start_i:
  - word_count_i > DEPTH: err_o=1, done_o=0, next state IDLE. cpu_rst_o is driven 0 and stays 0.
  - word_count_i == 0: err_o=0, done_o=1, cpu_rst_o=1, next state DONE. Zero cycles of transfer.
  - Otherwise: latch the count, clear the word index, byte counter, err_o and done_o; cpu_rst_o=0; next state RECV.
- RECV:
  - byte_ready_o=1, busy_o=1.
  - A byte is accepted when byte_valid_i && byte_ready_o. It shifts into the packing register: word = {word[23:0], byte}.
  - The byte counter (2 bits) increments per accepted byte. On the 4th accepted byte, the next state is WRITE.
  - byte_valid_i low stalls indefinitely; no timeout.
- WRITE, exactly one cycle:
  - byte_ready_o=0, mem_we_o=1, mem_data_o = packed word.
  - mem_addr_o = BASE_ADDR + 4*index, 32-bit arithmetic.
  - Index increments. If the new index == latched count, next state is DONE; otherwise RECV.
- DONE: done_o=1, busy_o=0, cpu_rst_o=1. A new start_i re-enters the flow above, and cpu_rst_o drops to 0 in the following cycle.
- Timing:
  - Outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
  - Peak throughput is 4 bytes per 5 cycles.
  - The memory write occurs in the cycle after the 4th byte handshake.
  - done_o and cpu_rst_o rise in the cycle after the final WRITE.
- start_i during RECV or WRITE is ignored.
- mem_addr_o and mem_data_o hold their last values when mem_we_o=0.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, RECV, WRITE, DONE);
  - BYTES_PER_WORD = 4;
  - WORD_BYTES_SHIFT = 2.
- One sub-module, byte_packer: owns the 32-bit shift register and the 2-bit byte counter, and emits word_ready when 4 bytes have been accepted.
- The FSM, address and index logic stay in instr_loader.

Test Plan:
1. Reset behaviour: hold rst_i low mid-stream, then release. Expect every output 0, state IDLE, and no mem_we_o until the next start_i.
2. Single-word load: start_i with word_count_i=1, bytes 0x20,0x08,0x00,0x05 sent back-to-back. Expect one mem_we_o pulse with addr 0x00000000 and data 0x20080005. done_o=1 and cpu_rst_o=1 one cycle after the write.
3. Multi-word load with stalls: word_count_i=3, byte_valid_i toggled randomly. Expect writes to 0x0, 0x4, 0x8 with the correct packed words, byte_ready_o=0 in each WRITE cycle, and no byte lost or duplicated.
4. Zero and overflow counts:
   - word_count_i=0: expect done_o=1 and cpu_rst_o=1 with no write.
   - word_count_i=DEPTH+1 (33): expect err_o=1, cpu_rst_o=0, no write, state IDLE.
5. Start ignored while busy: assert start_i during RECV of word 1 of 2. Expect the load to continue unchanged and exactly 2 writes.
6. Reload from DONE, with BASE_ADDR=0x100: after one completed load, issue start_i with word_count_i=2. Expect cpu_rst_o to drop the next cycle, writes to 0x100 and 0x104, then done_o to reassert.
